// File: rtl/if_row_packetizer.sv
// Ifmap row packetizer: packs the serial spike stream one bit per address into 25-bit rows.
// Each completed row becomes a NoC packet held in a 2-entry FIFO for the router.
// Out-of-order addresses and timesteps set a sticky error flag.
module if_row_packetizer #(
  parameter int unsigned ROWS          = 25,
  parameter int unsigned COLS          = 25,
  parameter int unsigned WIDTH_packet  = 57,
  parameter int unsigned WIDTH_payload = 40,
  parameter int unsigned NODE          = 12,
  parameter int unsigned DEST_BASE     = 1,
  parameter int unsigned NUM_PE        = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_start,
  input  logic                    load_done,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [9:0]              in_addr,
  input  logic                    in_data,
  input  logic [1:0]              in_timestep,
  output logic                    pkt_valid,
  input  logic                    pkt_ready,
  output logic [WIDTH_packet-1:0] pkt_data,
  output logic                    busy,
  output logic                    err_order
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           col_q, col_d;
  logic [RW-1:0]           row_q, row_d;
  logic [PW-1:0]           pe_q, pe_d;
  logic [9:0]              exp_q, exp_d;
  logic [1:0]              row_ts_q, row_ts_d;
  logic [COLS-1:0]         rowbuf_q, rowbuf_d;
  logic                    err_q, err_d;
  logic                    flush_q, flush_d;

  logic [WIDTH_packet-1:0] mem_q [2];
  logic                    rd_q, wr_q;
  logic [1:0]              cnt_q;

  logic                    accept, pop, push, clear;
  logic [WIDTH_packet-1:0] push_data;
  logic [COLS-1:0]         beat_bits;
  logic [1:0]              beat_ts;

  function automatic logic [WIDTH_packet-1:0] make_pkt(input logic [PW-1:0]   pe,
                                                       input logic [RW-1:0]   row,
                                                       input logic [1:0]      ts,
                                                       input logic [COLS-1:0] bits);
    logic [WIDTH_packet-1:0] p;
    p                     = '0;
    p[56:53]              = 4'(DEST_BASE + pe);
    p[52:49]              = 4'(NODE);
    p[48:47]              = 2'b01;
    p[46:45]              = ts;
    p[44:40]              = 5'(row);
    p[WIDTH_payload-1:0]  = WIDTH_payload'(bits);
    return p;
  endfunction

  assign in_ready  = (state_q == StLoad) && (cnt_q < 2'd2);
  assign pkt_valid = (cnt_q != 2'd0);
  assign pkt_data  = mem_q[rd_q];
  assign busy      = (state_q != StIdle);
  assign err_order = err_q;
  assign accept    = in_valid && in_ready;
  assign pop       = pkt_valid && pkt_ready;

  // Next-state: session control, row assembly and packet push decisions
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    pe_d      = pe_q;
    exp_d     = exp_q;
    row_ts_d  = row_ts_q;
    rowbuf_d  = rowbuf_q;
    err_d     = err_q;
    flush_d   = flush_q;
    push      = 1'b0;
    clear     = 1'b0;
    push_data = '0;
    beat_bits = rowbuf_q;
    beat_bits[col_q] = in_data;
    // At col 0 the row timestep is being captured this very cycle
    beat_ts   = (col_q == '0) ? in_timestep : row_ts_q;
    unique case (state_q)
      StIdle: begin
        if (load_start) begin
          state_d  = StLoad;
          col_d    = '0;
          row_d    = '0;
          pe_d     = '0;
          exp_d    = '0;
          rowbuf_d = '0;
          err_d    = 1'b0;
          flush_d  = 1'b0;
          clear    = 1'b1;
        end
      end
      StLoad: begin
        if (accept) begin
          rowbuf_d = beat_bits;
          if (in_addr != exp_q) err_d = 1'b1;
          if (col_q == '0) row_ts_d = in_timestep;
          else if (in_timestep != row_ts_q) err_d = 1'b1;
          exp_d = (exp_q == 10'(ROWS * COLS - 1)) ? '0 : exp_q + 10'd1;
          if (col_q == CW'(COLS - 1)) begin
            push      = 1'b1;
            push_data = make_pkt(pe_q, row_q, beat_ts, beat_bits);
            col_d     = '0;
            rowbuf_d  = '0;
            if (row_q == RW'(ROWS - 1)) begin
              row_d = '0;
              pe_d  = '0;
              exp_d = '0;
            end else begin
              row_d = row_q + 1'b1;
              pe_d  = (pe_q == PW'(NUM_PE - 1)) ? '0 : pe_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        // A beat on the same cycle is folded in first, so look at col_d
        if (load_done) begin
          state_d = StDrain;
          flush_d = (col_d != '0);
        end
      end
      StDrain: begin
        if (flush_q) begin
          if ((cnt_q < 2'd2) || pop) begin
            push      = 1'b1;
            push_data = make_pkt(pe_q, row_q, row_ts_q, rowbuf_q);
            flush_d   = 1'b0;
            col_d     = '0;
            rowbuf_d  = '0;
          end
        end else if (cnt_q == 2'd0) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and row-assembly registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      col_q    <= '0;
      row_q    <= '0;
      pe_q     <= '0;
      exp_q    <= '0;
      row_ts_q <= '0;
      rowbuf_q <= '0;
      err_q    <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      pe_q     <= pe_d;
      exp_q    <= exp_d;
      row_ts_q <= row_ts_d;
      rowbuf_q <= rowbuf_d;
      err_q    <= err_d;
      flush_q  <= flush_d;
    end
  end

  // Two-entry packet FIFO; when full, a push lands in the slot being popped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (clear) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_if_row_packetizer.sv
// Bench for if_row_packetizer: directed sessions against a beat-count packet model.
module tb_if_row_packetizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start = 1'b0;
  logic        load_done = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [9:0]  in_addr = '0;
  logic        in_data = 1'b0;
  logic [1:0]  in_timestep = '0;
  logic        pkt_valid;
  logic        pkt_ready = 1'b0;
  logic [56:0] pkt_data;
  logic        busy;
  logic        err_order;

  int n_checks = 0;
  int n_errs   = 0;

  // Model state: beats accepted this session, current row bits/timestep, error
  int          m_k = 0;
  logic [24:0] m_bits = '0;
  logic [1:0]  m_ts = '0;
  logic        m_err = 1'b0;
  logic [56:0] expq[$];
  logic [56:0] gotq[$];
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  if_row_packetizer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_done  (load_done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .in_timestep(in_timestep),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_data   (pkt_data),
    .busy       (busy),
    .err_order  (err_order)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet layout straight from the field table
  function automatic logic [56:0] mk(input int row, input logic [1:0] ts, input logic [24:0] bits);
    return {4'(1 + row % 5), 4'd12, 2'b01, ts, 5'(row), 15'd0, bits};
  endfunction

  function automatic void model_beat(input logic [9:0] addr, input logic d, input logic [1:0] ts);
    int col = m_k % 25;
    int row = (m_k / 25) % 25;
    if (int'(addr) != m_k % 625) m_err = 1'b1;
    if (col == 0) begin
      m_ts   = ts;
      m_bits = '0;
    end else if (ts != m_ts) begin
      m_err = 1'b1;
    end
    m_bits[col] = d;
    m_k++;
    if (col == 24) expq.push_back(mk(row, m_ts, m_bits));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [9:0] addr, input logic d, input logic [1:0] ts);
    bit ok = 1'b0;
    in_valid    = 1'b1;
    in_addr     = addr;
    in_data     = d;
    in_timestep = ts;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    if (ok) model_beat(addr, d, ts);
    else begin
      n_checks++;
      n_errs++;
      $display("FAIL beat_timeout: in_ready got 0 expected 1 (addr %0d)", addr);
    end
    in_valid = 1'b0;
  endtask

  task automatic start_session();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_k   = 0;
    m_err = 1'b0;
    expq.delete();
    gotq.delete();
  endtask

  task automatic end_session();
    int col = m_k % 25;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    if (col != 0) expq.push_back(mk((m_k / 25) % 25, m_ts, m_bits));
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (busy && i < 200) begin
      tick();
      i++;
    end
    check({name, "_idle"}, 64'(busy), 64'(0));
    check({name, "_drained"}, 64'(expq.size()), 64'(0));
  endtask

  // Compare process: every handshake against the model, err_order every cycle
  always @(negedge clk) begin
    logic [56:0] e;
    if (mon_en) begin
      if (pkt_valid && pkt_ready) begin
        gotq.push_back(pkt_data);
        if (expq.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_pkt: got %h expected none", pkt_data);
        end else begin
          e = expq.pop_front();
          check("pkt_data", 64'(pkt_data), 64'(e));
        end
      end
      check("err_order", 64'(err_order), 64'(m_err));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dest_tab[6] = '{1, 2, 3, 4, 5, 1};
    logic [9:0] pat = 10'h2CD;
    bit seen;

    // Reset values
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_pkt_valid", 64'(pkt_valid), 64'(0));
    check("rst_pkt_data", 64'(pkt_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_err", 64'(err_order), 64'(0));
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Two full timesteps, alternating bits, router always ready
    pkt_ready = 1'b1;
    start_session();
    check("t1_in_ready_rise", 64'(in_ready), 64'(1));
    check("t1_busy", 64'(busy), 64'(1));
    for (int k = 0; k < 1250; k++) send_beat(10'(k % 625), 1'(k % 2), (k < 625) ? 2'd1 : 2'd2);
    end_session();
    wait_idle("t1");
    check("t1_npkt", 64'(gotq.size()), 64'(50));
    check("t1_row0", 64'(gotq[0][24:0]), 64'(25'h0AAAAAA));
    check("t1_row1", 64'(gotq[1][24:0]), 64'(25'h1555555));
    for (int i = 0; i < 6; i++) check("t1_dest", 64'(gotq[i][56:53]), 64'(dest_tab[i]));
    check("t1_node", 64'(gotq[0][52:49]), 64'(4'hC));
    check("t1_type", 64'(gotq[0][48:47]), 64'(2'b01));
    check("t1_ts", 64'(gotq[0][46:45]), 64'(1));
    check("t1_row24", 64'(gotq[24][44:40]), 64'(24));
    check("t2_row0", 64'(gotq[25][24:0]), 64'(25'h1555555));
    check("t2_ts", 64'(gotq[25][46:45]), 64'(2));
    check("t2_rownum", 64'(gotq[25][44:40]), 64'(0));
    check("t1_err", 64'(err_order), 64'(0));

    // Backpressure: two rows buffered, then in_ready must drop
    pkt_ready = 1'b0;
    start_session();
    for (int k = 0; k < 50; k++) send_beat(10'(k), 1'(k % 2), 2'd1);
    in_valid = 1'b1;
    in_addr = 10'd50;
    in_data = 1'b0;
    in_timestep = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_pkt_valid", 64'(pkt_valid), 64'(1));
      check("bp_pkt_hold", 64'(pkt_data), 64'({4'd1, 4'd12, 2'b01, 2'd1, 5'd0, 15'd0, 25'h0AAAAAA}));
      tick();
    end
    pkt_ready = 1'b1;
    for (int k = 50; k < 100; k++) send_beat(10'(k), 1'(k % 2), 2'd1);
    end_session();
    wait_idle("bp");
    check("bp_npkt", 64'(gotq.size()), 64'(4));
    check("bp_row2", 64'(gotq[2][24:0]), 64'(25'h0AAAAAA));
    check("bp_row2_num", 64'(gotq[2][44:40]), 64'(2));

    // Address skip at beat 4
    start_session();
    for (int k = 0; k < 25; k++) send_beat((k == 4) ? 10'd5 : 10'(k), 1'b1, 2'd0);
    check("skip_err", 64'(err_order), 64'(1));
    end_session();
    wait_idle("skip");
    check("skip_sticky", 64'(err_order), 64'(1));
    check("skip_npkt", 64'(gotq.size()), 64'(1));
    check("skip_row0", 64'(gotq[0][24:0]), 64'(25'h1FFFFFF));

    // Partial row flushed by load_done; load_start clears the error
    start_session();
    check("flush_err_clr", 64'(err_order), 64'(0));
    for (int k = 0; k < 10; k++) send_beat(10'(k), pat[k], 2'd3);
    end_session();
    wait_idle("flush");
    check("flush_npkt", 64'(gotq.size()), 64'(1));
    check("flush_bits", 64'(gotq[0][24:0]), 64'(25'h00002CD));
    check("flush_hi_zero", 64'(gotq[0][24:10]), 64'(0));
    check("flush_ts", 64'(gotq[0][46:45]), 64'(3));
    check("flush_dest", 64'(gotq[0][56:53]), 64'(1));
    check("flush_err", 64'(err_order), 64'(0));

    // Reset mid-row with one packet buffered
    pkt_ready = 1'b0;
    start_session();
    for (int k = 0; k < 30; k++) send_beat(10'(k), 1'(k % 2), 2'd1);
    check("mr_pkt_valid", 64'(pkt_valid), 64'(1));
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mr_in_ready", 64'(in_ready), 64'(0));
    check("mr_pkt_valid0", 64'(pkt_valid), 64'(0));
    check("mr_pkt_data", 64'(pkt_data), 64'(0));
    check("mr_busy", 64'(busy), 64'(0));
    check("mr_err", 64'(err_order), 64'(0));
    expq.delete();
    m_k = 0;
    m_err = 1'b0;
    tick();
    rst_n = 1'b1;
    pkt_ready = 1'b1;
    mon_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pkt_valid) seen = 1'b1;
    end
    check("mr_no_pkt", 64'(seen), 64'(0));
    check("mr_idle", 64'(busy), 64'(0));

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
